tt_mux_ctrl: RTL

Project-select controller for the muxperiment array. It owns which wrapped TinyTapeout project is live. It drives each wrapper's `ena` as a one-hot vector and produces the gated project reset that is packed into the wrapper input bus. It also steers the selected wrapper's 24-bit output bus back to the shared pads. Every project switch runs a fixed disable, reset and release sequence, so no project ever starts from undefined state.

---
 rtl/tt_mux_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/tt_mux_ctrl.sv
// ---------------------------------------------------------------------------
// tt_mux_ctrl
//
// Project-select controller for the muxperiment array. Decides which wrapped
// TinyTapeout project is live, drives the one-hot wrapper enables, generates
// the gated project reset, and steers the live project's 24-bit output bus
// back to the shared pads. Every project switch walks through a fixed
// SWAP -> HOLD -> ACTIVE sequence so a project never starts from undefined
// state.
//
// Parameters:
//   NUM_PROJ  number of wrapped projects
//   IDX_W     width of the project index (2**IDX_W >= NUM_PROJ)
//   RST_HOLD  cycles the project reset stays low with the new project enabled
//
// Ports:
//   i_clk         single clock, shared with all wrappers
//   i_rst_n       asynchronous active-low reset
//   i_req_valid   select request valid
//   i_req_idx     requested project index
//   o_req_ready   controller can accept a request (ACTIVE only)
//   o_req_err     one-cycle pulse after accepting an out-of-range index
//   o_ena         one-hot wrapper enable
//   o_proj_rst_n  project reset, packed into each wrapper's iw[1]
//   o_cur_sel     index of the currently selected project
//   o_busy        high whenever the controller is not ACTIVE
//   i_ow_bus      concatenated wrapper outputs, project k at [24k+23:24k]
//   o_ow_out      output bus of the selected project (zero unless ACTIVE)
// ---------------------------------------------------------------------------
module tt_mux_ctrl #(
  parameter int NUM_PROJ = 16,
  parameter int IDX_W    = 4,
  parameter int RST_HOLD = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  input  logic [IDX_W-1:0]         i_req_idx,
  output logic                     o_req_ready,
  output logic                     o_req_err,
  output logic [NUM_PROJ-1:0]      o_ena,
  output logic                     o_proj_rst_n,
  output logic [IDX_W-1:0]         o_cur_sel,
  output logic                     o_busy,
  input  logic [NUM_PROJ*24-1:0]   i_ow_bus,
  output logic [23:0]              o_ow_out
);

  // A one-cycle hold still needs a one-bit counter.
  localparam int                CNT_W      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CNT_W-1:0]  HOLD_INIT  = CNT_W'(RST_HOLD - 1);
  // One extra bit so NUM_PROJ itself is representable when IDX_W is tight.
  localparam logic [IDX_W:0]    NUM_PROJ_L = (IDX_W + 1)'(NUM_PROJ);

  typedef enum logic [1:0] {
    ST_SWAP,
    ST_HOLD,
    ST_ACTIVE
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_cur_sel;
  logic [IDX_W-1:0]  r_pending;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req_err;

  state_t            w_state_nxt;
  logic [IDX_W-1:0]  w_cur_sel_nxt;
  logic [IDX_W-1:0]  w_pending_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_req_err_nxt;
  logic              w_idx_ok;
  logic [NUM_PROJ-1:0] w_onehot;
  logic [23:0]       w_slice;

  // Reset lands in HOLD with project 0 enabled, so project 0 sees a full
  // RST_HOLD-cycle reset window after rst_n is released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_HOLD;
      r_cur_sel <= '0;
      r_pending <= '0;
      r_cnt     <= HOLD_INIT;
      r_req_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_sel <= w_cur_sel_nxt;
      r_pending <= w_pending_nxt;
      r_cnt     <= w_cnt_nxt;
      r_req_err <= w_req_err_nxt;
    end
  end

  assign w_idx_ok = ({1'b0, i_req_idx} < NUM_PROJ_L);
  // cur_sel only ever holds in-range indices, so the shift never overflows.
  assign w_onehot = NUM_PROJ'(1) << r_cur_sel;

  // Next-state logic and state-decoded outputs. Outputs depend on r_state
  // and r_cur_sel only, never on the request inputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_cur_sel_nxt = r_cur_sel;
    w_pending_nxt = r_pending;
    w_cnt_nxt     = r_cnt;
    w_req_err_nxt = 1'b0;
    o_ena         = '0;
    o_proj_rst_n  = 1'b0;
    o_req_ready   = 1'b0;
    o_busy        = 1'b1;

    case (r_state)
      ST_SWAP: begin
        // All enables low for exactly this one cycle.
        w_state_nxt   = ST_HOLD;
        w_cur_sel_nxt = r_pending;
        w_cnt_nxt     = HOLD_INIT;
      end
      ST_HOLD: begin
        o_ena = w_onehot;
        if (r_cnt == '0) begin
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_ACTIVE: begin
        o_ena        = w_onehot;
        o_proj_rst_n = 1'b1;
        o_req_ready  = 1'b1;
        o_busy       = 1'b0;
        if (i_req_valid) begin
          if (w_idx_ok) begin
            // Same index is allowed: it re-runs the reset sequence.
            w_pending_nxt = i_req_idx;
            w_state_nxt   = ST_SWAP;
          end else begin
            w_req_err_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = HOLD_INIT;
      end
    endcase
  end

  // Output steering: pick the selected project's 24-bit slice.
  always_comb begin
    w_slice = '0;
    for (int k = 0; k < NUM_PROJ; k++) begin
      if (r_cur_sel == IDX_W'(k)) begin
        w_slice = i_ow_bus[24*k +: 24];
      end
    end
  end

  assign o_ow_out  = (r_state == ST_ACTIVE) ? w_slice : 24'h0;
  assign o_cur_sel = r_cur_sel;
  assign o_req_err = r_req_err;

endmodule
